// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding, FSM states
// and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
// wr is low for a divide by zero so the caller leaves HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        wr
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic        sgn;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    sgn     = (op == OP_DIV);
    ma      = (sgn && a[31]) ? (32'd0 - a) : a;
    mb      = (sgn && b[31]) ? (32'd0 - b) : b;
    divisor = (mb == 32'd0) ? 32'd1 : mb;
    uq      = ma / divisor;
    ur      = ma % divisor;
    q       = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    r       = (sgn && a[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    res = '0;
    wr  = 1'b0;
    case (op)
      OP_MULT:  begin res = smul; wr = 1'b1; end
      OP_MULTU: begin res = umul; wr = 1'b1; end
      OP_DIV, OP_DIVU: begin
        res = {r, q};
        wr  = (b != 32'd0);
      end
      default: begin res = '0; wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// MIPS E-stage multiply/divide unit with architectural HI/LO and a busy flag for
// the hazard unit. Define MDU_CANCEL_EN to add the cancel (exception flush) input.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] ar_res;
  logic        ar_wr;
  logic        flush;

`ifdef MDU_CANCEL_EN
  assign flush = cancel;
`else
  assign flush = 1'b0;
`endif

  mdu_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (ar_res),
    .wr  (ar_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (is_mul(op) || is_div(op)) begin
              op_q  <= op;
              a_q   <= A;
              b_q   <= B;
              cnt   <= is_mul(op) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
              busy  <= 1'b1;
              state <= BUSY;
            end else if (op == OP_MTHI) begin
              HI <= A;
            end else if (op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 32'd1) begin
            if (ar_wr) begin
              HI <= ar_res[63:32];
              LO <= ar_res[31:0];
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (op == OP_MFHI)
      result = HI;
    else if (op == OP_MFLO)
      result = LO;
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: each mult/div pushes its expected busy length and HI/LO;
// a monitor pops and compares whenever busy falls.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];
  logic        prev_busy = 1'b0;
  int unsigned bcnt = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: completion is the cycle busy drops; an async reset discards the op in flight.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (busy) bcnt++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion got=HI %h LO %h exp=none", HI, LO);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_cycles"}, bcnt, e.cyc);
          chk({e.name, "_HI"}, HI, e.hi);
          chk({e.name, "_LO"}, LO, e.lo);
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic expect_op(input string nm, input int unsigned cyc,
                           input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  // One-cycle start pulse; operands are scrambled afterwards to prove they were latched.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = OP_NONE; A = 32'hDEADBEEF; B = 32'h0BADF00D;
  endtask

  task automatic wait_idle(input int unsigned maxc);
    int unsigned n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout got=busy 1 exp=busy 0");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NONE; A = '0; B = '0; cancel = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    expect_op("mult_neg", MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(40);

    expect_op("multu", MC, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle(40);
    @(negedge clk);
    op = OP_MFHI; #1 chk("mfhi", result, 32'h00000001);
    op = OP_MFLO; #1 chk("mflo", result, 32'hFFFFFFFE);
    op = OP_NONE; #1 chk("result_none", result, 32'd0);

    expect_op("div_neg_dividend", DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(40);

    expect_op("div_neg_divisor", DC, 32'h00000001, 32'hFFFFFFFD);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle(40);

    expect_op("divu", DC, 32'd2, 32'd14);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(40);

    issue(OP_MTHI, 32'h11, 32'd0);
    chk("mthi_HI", HI, 32'h11);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    chk("mtlo_LO", LO, 32'h22);
    chk("mtlo_HI_kept", HI, 32'h11);

    expect_op("divu_by_zero", DC, 32'h11, 32'h22);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(40);

    expect_op("div_overflow", DC, 32'd0, 32'h80000000);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(40);

    // A second start while busy must be dropped.
    expect_op("start_while_busy", MC, 32'd0, 32'd12);
    issue(OP_MULT, 32'd3, 32'd4);
    start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    wait_idle(40);

    // Async reset in the third busy cycle of a DIV.
    issue(OP_DIV, 32'd50, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_HI", HI, 32'd0);
    chk("post_abort_LO", LO, 32'd0);

`ifdef MDU_CANCEL_EN
    issue(OP_MTHI, 32'h5, 32'd0);
    issue(OP_MTLO, 32'h6, 32'd0);
    expect_op("cancel_mult", 2, 32'h5, 32'h6);
    issue(OP_MULT, 32'd9, 32'd9);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle(40);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; A = 32'h99; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NONE; cancel = 1'b0;
    chk("cancel_mthi_HI", HI, 32'h5);
`endif

    wait_idle(40);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
